// File: rtl/prof_ctrl.sv
// Session controller for the PC-range instruction profiler: holds the PC window,
// trigger PC and cycle limit, and sequences IDLE -> ARMED -> RUN -> DONE.
module prof_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:PC_W-1]  P_Trace_PC,
  input  logic             P_Trace_Valid_Instr,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic [1:0]       state,
  output logic             done_pulse,
  output logic [CNT_W-1:0] run_cycles
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] A_WIN_LO  = 3'd0;
  localparam logic [2:0] A_WIN_HI  = 3'd1;
  localparam logic [2:0] A_TRIG_PC = 3'd2;
  localparam logic [2:0] A_LIMIT   = 3'd3;
  localparam logic [2:0] A_CTRL    = 3'd4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  win_lo_q, win_lo_d;
  logic [PC_W-1:0]  win_hi_q, win_hi_d;
  logic [PC_W-1:0]  trig_q, trig_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic             en_q, en_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;

  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] rc_inc;
  logic             ctrl_wr, start_cmd, stop_cmd, clear_cmd;
  logic             cfg_open, match, trig_hit, limit_hit;

  // Port PC has bit 0 as MSB; the plain copy keeps numeric order for the compares.
  assign pc        = P_Trace_PC;
  assign ctrl_wr   = cfg_we && (cfg_addr == A_CTRL);
  assign stop_cmd  = ctrl_wr && cfg_wdata[1];
  assign start_cmd = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
  assign clear_cmd = ctrl_wr && cfg_wdata[2];
  assign cfg_open  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign match     = P_Trace_Valid_Instr && (win_lo_q <= pc) && (pc <= win_hi_q);
  assign trig_hit  = P_Trace_Valid_Instr && (pc == trig_q);
  assign rc_inc    = sat_inc(rc_q);
  assign limit_hit = (limit_q != '0) && (rc_inc == limit_q);

  always_comb begin
    state_d  = state_q;
    win_lo_d = win_lo_q;
    win_hi_d = win_hi_q;
    trig_d   = trig_q;
    limit_d  = limit_q;
    rc_d     = rc_q;
    en_d     = 1'b0;
    clr_d    = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_cmd || clear_cmd) begin
          clr_d = 1'b1;
          rc_d  = '0;
        end
        if (start_cmd) state_d = S_ARMED;
        if (cfg_we) begin
          case (cfg_addr)
            A_WIN_LO:  win_lo_d = PC_W'(cfg_wdata);
            A_WIN_HI:  win_hi_d = PC_W'(cfg_wdata);
            A_TRIG_PC: trig_d   = PC_W'(cfg_wdata);
            A_LIMIT:   limit_d  = CNT_W'(cfg_wdata);
            default:   ;
          endcase
        end
      end
      S_ARMED: begin
        if (stop_cmd) begin
          state_d = S_IDLE;
        end else if (trig_hit) begin
          // The trigger instruction itself is counted when it falls in the window.
          state_d = S_RUN;
          en_d    = match;
        end
      end
      S_RUN: begin
        en_d = match;
        rc_d = rc_inc;
        if (stop_cmd || limit_hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      win_lo_q <= '0;
      win_hi_q <= '0;
      trig_q   <= '0;
      limit_q  <= '0;
      rc_q     <= '0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_lo_q <= win_lo_d;
      win_hi_q <= win_hi_d;
      trig_q   <= trig_d;
      limit_q  <= limit_d;
      rc_q     <= rc_d;
      en_q     <= en_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
    end
  end

  assign state      = state_q;
  assign cnt_enable = en_q;
  assign cnt_clear  = clr_q;
  assign done_pulse = done_q;
  assign run_cycles = rc_q;

endmodule

// File: tb/tb_prof_ctrl.sv
// Bench for prof_ctrl: constant-table and hand sequences for the session corner cases,
// then random traffic compared cycle by cycle against a behavioural session model.
module tb_prof_ctrl;

  logic        clk;
  logic        reset;
  logic [0:31] pc_i;
  logic        valid_i;
  logic        we_i;
  logic [2:0]  addr_i;
  logic [31:0] wdata_i;
  logic        cnt_enable;
  logic        cnt_clear;
  logic [1:0]  state;
  logic        done_pulse;
  logic [31:0] run_cycles;

  prof_ctrl #(.PC_W(32), .CNT_W(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .P_Trace_PC          (pc_i),
    .P_Trace_Valid_Instr (valid_i),
    .cfg_we              (we_i),
    .cfg_addr            (addr_i),
    .cfg_wdata           (wdata_i),
    .cnt_enable          (cnt_enable),
    .cnt_clear           (cnt_clear),
    .state               (state),
    .done_pulse          (done_pulse),
    .run_cycles          (run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Behavioural session model: mode 0..3 = idle, armed, run, done (the visible state code).
  localparam longint RC_MAX = 64'h0000_0000_FFFF_FFFF;
  int          m_mode;
  logic [31:0] m_lo, m_hi, m_trig, m_limit;
  longint      m_rc;
  bit          m_en, m_clr, m_done;

  task automatic model_reset();
    m_mode = 0; m_lo = 0; m_hi = 0; m_trig = 0; m_limit = 0;
    m_rc = 0; m_en = 0; m_clr = 0; m_done = 0;
  endtask

  task automatic model_step(input bit we, input int addr, input logic [31:0] wd,
                            input bit v, input logic [31:0] pcv);
    bit is_ctrl, start, stop, clr, in_win, hit, configurable;
    int nmode;
    is_ctrl      = we && (addr == 4);
    stop         = is_ctrl && wd[1];
    start        = is_ctrl && wd[0] && !stop;
    clr          = is_ctrl && wd[2];
    in_win       = v && (pcv >= m_lo) && (pcv <= m_hi);
    hit          = v && (pcv == m_trig);
    configurable = (m_mode == 0) || (m_mode == 3);
    nmode  = m_mode;
    m_en   = 0;
    m_clr  = 0;
    m_done = 0;
    if (configurable) begin
      if (start || clr) begin m_clr = 1; m_rc = 0; end
      if (start) nmode = 1;
      if (we && addr == 0) m_lo = wd;
      if (we && addr == 1) m_hi = wd;
      if (we && addr == 2) m_trig = wd;
      if (we && addr == 3) m_limit = wd;
    end else if (m_mode == 1) begin
      if (stop) nmode = 0;
      else if (hit) begin nmode = 2; m_en = in_win; end
    end else begin
      m_en = in_win;
      m_rc = (m_rc >= RC_MAX) ? RC_MAX : m_rc + 1;
      if (stop || (m_limit != 0 && m_rc == m_limit)) begin nmode = 3; m_done = 1; end
    end
    m_mode = nmode;
  endtask

  task automatic drive(input bit we, input logic [2:0] addr, input logic [31:0] wd,
                       input bit v, input logic [31:0] pcv, input string tag);
    we_i = we; addr_i = addr; wdata_i = wd; valid_i = v; pc_i = pcv;
    model_step(we, int'(addr), wd, v, pcv);
    @(posedge clk);
    #1;
    chk({tag, ".state"}, state, m_mode);
    chk({tag, ".en"}, cnt_enable, m_en);
    chk({tag, ".clr"}, cnt_clear, m_clr);
    chk({tag, ".done"}, done_pulse, m_done);
    chk({tag, ".rc"}, run_cycles, m_rc);
    we_i = 0; valid_i = 0;
  endtask

  task automatic idle(input string tag);
    drive(0, 3'd0, 32'h0, 0, 32'h0, tag);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input string tag);
    drive(1, a, d, 0, 32'h0, tag);
  endtask
  task automatic tr(input logic [31:0] p, input string tag);
    drive(0, 3'd0, 32'h0, 1, p, tag);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  addr;
    logic [31:0] wd;
    bit          v;
    logic [31:0] pc;
    logic [1:0]  st;
    bit          en;
    bit          clr;
    bit          dn;
    logic [31:0] rc;
  } vec_t;

  vec_t tbl[11];
  int   n2, ndp, nen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 3'd0, 32'h1C8, 0, 32'h0,   2'd0, 0, 0, 0, 32'd0};
    tbl[1]  = '{1, 3'd1, 32'h1EC, 0, 32'h0,   2'd0, 0, 0, 0, 32'd0};
    tbl[2]  = '{1, 3'd2, 32'h100, 0, 32'h0,   2'd0, 0, 0, 0, 32'd0};
    tbl[3]  = '{1, 3'd4, 32'h1,   0, 32'h0,   2'd1, 0, 1, 0, 32'd0};
    tbl[4]  = '{0, 3'd0, 32'h0,   0, 32'h0,   2'd1, 0, 0, 0, 32'd0};
    tbl[5]  = '{0, 3'd0, 32'h0,   1, 32'h1C8, 2'd1, 0, 0, 0, 32'd0};
    tbl[6]  = '{0, 3'd0, 32'h0,   1, 32'h100, 2'd2, 0, 0, 0, 32'd0};
    tbl[7]  = '{0, 3'd0, 32'h0,   1, 32'h1C8, 2'd2, 1, 0, 0, 32'd1};
    tbl[8]  = '{0, 3'd0, 32'h0,   1, 32'h1EC, 2'd2, 1, 0, 0, 32'd2};
    tbl[9]  = '{0, 3'd0, 32'h0,   1, 32'h1F0, 2'd2, 0, 0, 0, 32'd3};
    tbl[10] = '{0, 3'd0, 32'h0,   0, 32'h0,   2'd2, 0, 0, 0, 32'd4};

    reset = 0; we_i = 0; addr_i = 0; wdata_i = 0; valid_i = 0; pc_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", state, 0);
    chk("rst.en", cnt_enable, 0);
    chk("rst.clr", cnt_clear, 0);
    chk("rst.done", done_pulse, 0);
    chk("rst.rc", run_cycles, 0);
    #2 reset = 1;

    // Window, trigger, start, then trace before and after the trigger.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].v, tbl[i].pc, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.k_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d.k_en", i), cnt_enable, tbl[i].en);
      chk($sformatf("tbl%0d.k_clr", i), cnt_clear, tbl[i].clr);
      chk($sformatf("tbl%0d.k_done", i), done_pulse, tbl[i].dn);
      chk($sformatf("tbl%0d.k_rc", i), run_cycles, tbl[i].rc);
    end

    // Limit of 10 with in-window traffic throughout the run.
    wr(3'd4, 32'h2, "lim.stop");
    wr(3'd3, 32'd10, "lim.wr");
    wr(3'd4, 32'h1, "lim.start");
    chk("lim.armed", state, 1);
    tr(32'h100, "lim.trig");
    n2 = (state == 2) ? 1 : 0; ndp = 0; nen = 0;
    for (int i = 0; i < 15; i++) begin
      tr(32'h1C8, "lim.run");
      if (state == 2) n2++;
      if (done_pulse) ndp++;
      if (cnt_enable) nen++;
    end
    chk("lim.run_cycles_in_state2", n2, 10);
    chk("lim.done_pulses", ndp, 1);
    chk("lim.enable_cycles", nen, 10);
    chk("lim.rc", run_cycles, 10);
    chk("lim.state", state, 3);
    chk("lim.en_after", cnt_enable, 0);

    // Unlimited run stopped on the 37th RUN cycle; then start+stop together.
    wr(3'd3, 32'd0, "stp.lim0");
    wr(3'd4, 32'h1, "stp.start");
    tr(32'h100, "stp.trig");
    for (int i = 0; i < 100 && run_cycles != 36; i++) idle("stp.wait");
    chk("stp.reach36", run_cycles, 36);
    wr(3'd4, 32'h2, "stp.stop");
    chk("stp.state", state, 3);
    chk("stp.rc", run_cycles, 37);
    chk("stp.done", done_pulse, 1);
    wr(3'd4, 32'h3, "stp.both");
    chk("stp.both_state", state, 3);
    chk("stp.both_clr", cnt_clear, 0);
    idle("stp.hold");
    chk("stp.hold_rc", run_cycles, 37);

    // Window write during RUN is dropped; the same write in DONE takes effect.
    wr(3'd4, 32'h1, "win.start");
    tr(32'h100, "win.trig");
    wr(3'd1, 32'hFFFF, "win.wr_run");
    tr(32'h200, "win.pc200");
    chk("win.dropped_en", cnt_enable, 0);
    wr(3'd4, 32'h2, "win.stop");
    wr(3'd1, 32'hFFFF, "win.wr_done");
    wr(3'd4, 32'h1, "win.start2");
    tr(32'h100, "win.trig2");
    tr(32'h200, "win.pc200b");
    chk("win.accepted_en", cnt_enable, 1);
    wr(3'd4, 32'h2, "win.stop2");

    // Inverted window never matches.
    wr(3'd0, 32'h1EC, "inv.lo");
    wr(3'd1, 32'h1C8, "inv.hi");
    wr(3'd4, 32'h1, "inv.start");
    tr(32'h100, "inv.trig");
    nen = 0;
    for (int i = 0; i < 50; i++) begin
      tr(32'h1C0 + (i * 48) / 49, "inv.sweep");
      if (cnt_enable) nen++;
    end
    chk("inv.enable_cycles", nen, 0);
    wr(3'd4, 32'h2, "inv.stop");

    // Asynchronous reset mid-run.
    wr(3'd4, 32'h1, "ar.start");
    tr(32'h100, "ar.trig");
    repeat (5) idle("ar.run");
    chk("ar.rc5", run_cycles, 5);
    #3 reset = 0;
    #1;
    model_reset();
    chk("ar.state", state, 0);
    chk("ar.rc", run_cycles, 0);
    chk("ar.en", cnt_enable, 0);
    chk("ar.clr", cnt_clear, 0);
    chk("ar.done", done_pulse, 0);
    @(posedge clk);
    #1;
    chk("ar.done_held", done_pulse, 0);
    #2 reset = 1;
    wr(3'd4, 32'h1, "ar.start2");
    tr(32'h0, "ar.trig0");
    chk("ar.trig_zero_state", state, 2);
    chk("ar.win_zero_en", cnt_enable, 1);
    tr(32'h1, "ar.pc1");
    chk("ar.win_hi_zero_en", cnt_enable, 0);
    wr(3'd4, 32'h2, "ar.stop");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          we, v;
      logic [2:0]  a;
      logic [31:0] d, p;
      we = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      d  = $urandom();
      if (a <= 3'd2) d = 32'($urandom_range(0, 63));
      if (a == 3'd3) d = 32'($urandom_range(0, 40));
      if (a == 3'd4) begin
        d[0] = ($urandom_range(0, 1) == 1);
        d[1] = ($urandom_range(0, 15) == 0);
        d[2] = ($urandom_range(0, 3) == 0);
      end
      v = ($urandom_range(0, 1) == 1);
      p = 32'($urandom_range(0, 63));
      drive(we, a, d, v, p, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
